// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction fetch sequencer (IDLE/FETCH/WAIT/ISSUE/HALT).
// Define PC_FETCH_TIMEOUT_EN to add the imem_ack wait timeout and fetch_error.
module pc_fetch_sequencer #(
  parameter int unsigned PC_INC         = 2,
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        halt,
  output logic [15:0] pc,
  output logic [15:0] pc_plus,
  output logic        halted,
  output logic        fetch_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  localparam logic [15:0] INC = 16'(PC_INC);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_plus_w;
  logic [15:0] next_pc;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

`ifdef PC_FETCH_TIMEOUT_EN
  localparam logic [3:0] TMO = 4'(TIMEOUT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  assign pc_plus_w = pc_q + INC;

  // Redirect priority: jump over branch over sequential
  always_comb begin
    next_pc = pc_plus_w;
    if (jump_en) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = pc_plus_w + branch_offset;
    end
  end

  // Next-state, next-PC and registered-output decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
`ifdef PC_FETCH_TIMEOUT_EN
        cnt_d = 4'd0;
`endif
        state_d = imem_ack ? S_ISSUE : S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d = S_ISSUE;
        end else begin
`ifdef PC_FETCH_TIMEOUT_EN
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TMO) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
`endif
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_d    = (state_d == S_FETCH);
    valid_d  = (state_d == S_ISSUE);
    halted_d = (state_d == S_HALT);
  end

  // State, PC and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
`ifdef PC_FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus     = pc_plus_w;
  assign halted      = halted_q;
`ifdef PC_FETCH_TIMEOUT_EN
  assign fetch_error = err_q;
`else
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed literal checks plus
// random traffic checked every cycle against a behavioural model.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        stall;
  logic        jump_en;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        halted;
  logic        fetch_error;

  pc_fetch_sequencer dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .halt         (halt),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .halted       (halted),
    .fetch_error  (fetch_error)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic cmp(string nm, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int IDLE = 0, FET = 1, WT = 2, ISS = 3, HLT = 4;
`ifdef PC_FETCH_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  int          m_phase = IDLE;
  logic [15:0] m_pc = 16'h0;
  bit          m_err = 1'b0;
  int          m_waits = 0;
  bit          chk_en = 1'b0;

  always @(posedge CLK) begin
    if (Reset) begin
      m_phase = IDLE;
      m_pc    = 16'h0000;
      m_err   = 1'b0;
      m_waits = 0;
    end else if (m_phase == IDLE) begin
      m_phase = FET;
    end else if (m_phase == FET) begin
      m_waits = 0;
      m_phase = imem_ack ? ISS : WT;
    end else if (m_phase == WT) begin
      if (imem_ack) begin
        m_phase = ISS;
      end else if (TMO_ON) begin
        m_waits++;
        if (m_waits == 15) begin
          m_phase = HLT;
          m_err   = 1'b1;
        end
      end
    end else if (m_phase == ISS && !stall) begin
      if (jump_en) m_pc = jump_target;
      else if (branch_taken) m_pc = 16'(int'(m_pc) + 2 + int'(branch_offset));
      else m_pc = 16'(int'(m_pc) + 2);
      m_phase = halt ? HLT : FET;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp("imem_req", imem_req, m_phase == FET);
      cmp("imem_addr", imem_addr, m_pc);
      cmp("instr_valid", instr_valid, m_phase == ISS);
      cmp("halted", halted, m_phase == HLT);
      cmp("pc", pc, m_pc);
      cmp("pc_plus", pc_plus, 16'(int'(m_pc) + 2));
      cmp("fetch_error", fetch_error, m_err);
    end
  end

  // ---------------- ack driver and observation log ----------------
  bit          ack_auto = 1'b0;
  bit          req_seen = 1'b0;
  logic [15:0] addr_log[$];
  int          vcount = 0;

  always @(negedge CLK) begin
    if (ack_auto) imem_ack = req_seen;
    req_seen = imem_req;
    if (imem_req) addr_log.push_back(imem_addr);
    if (instr_valid) vcount++;
  end

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) return;
      cyc();
    end
    cmp("wait_valid_timeout", 16'd1, 16'd0);
  endtask

  task automatic wait_req(output logic [15:0] a);
    a = 16'hxxxx;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin
        a = imem_addr;
        return;
      end
      cyc();
    end
    cmp("wait_req_timeout", 16'd1, 16'd0);
  endtask

  task automatic accept(bit j, logic [15:0] jt, bit b,
                        logic [15:0] bo, bit h);
    wait_valid();
    jump_en = j; jump_target = jt;
    branch_taken = b; branch_offset = bo; halt = h;
    cyc();
    jump_en = 0; branch_taken = 0; halt = 0;
  endtask

  logic [15:0] a;
  int          n;

  initial begin
    Reset = 1; imem_ack = 0; stall = 0; jump_en = 0;
    jump_target = 0; branch_taken = 0; branch_offset = 0; halt = 0;
    @(posedge CLK);
    @(negedge CLK);
    chk_en = 1;
    cyc();
    cmp("rst_pc", pc, 16'h0000);
    cmp("rst_req", imem_req, 1'b0);
    cmp("rst_valid", instr_valid, 1'b0);
    cmp("rst_halted", halted, 1'b0);
    cmp("rst_err", fetch_error, 1'b0);

    // three sequential fetches, ack one cycle after request
    ack_auto = 1;
    Reset = 0;
    addr_log.delete();
    vcount = 0;
    for (int k = 0; k < 3; k++) begin
      wait_valid();
      cyc();
    end
    cmp("seq_valid_pulses", 16'(vcount), 16'd3);
    cmp("seq_pc", pc, 16'h0006);
    cmp("seq_addr0", addr_log[0], 16'h0000);
    cmp("seq_addr1", addr_log[1], 16'h0002);
    cmp("seq_addr2", addr_log[2], 16'h0004);

    // branch and jump-over-branch
    accept(1, 16'h0010, 0, 0, 0);
    wait_valid();
    cmp("br_pc", pc, 16'h0010);
    accept(0, 0, 1, 16'hFFF8, 0);
    wait_req(a);
    cmp("br_target", a, 16'h000A);
    accept(1, 16'h0010, 0, 0, 0);
    accept(1, 16'h1234, 1, 16'hFFF8, 0);
    wait_req(a);
    cmp("jmp_over_br", a, 16'h1234);

    // stall holds issue, redirect and halt ignored
    accept(1, 16'h0004, 0, 0, 0);
    wait_valid();
    cmp("stall_pc", pc, 16'h0004);
    n = 0;
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      if (instr_valid) n++;
      jump_en = (i == 1); jump_target = 16'h5555; halt = (i == 2);
      cyc();
    end
    stall = 0; jump_en = 0; halt = 0;
    if (instr_valid) n++;
    cyc();
    cmp("stall_valid_cycles", 16'(n), 16'd5);
    wait_req(a);
    cmp("stall_next", a, 16'h0006);

    // wrap at top of address space
    accept(1, 16'hFFFE, 0, 0, 0);
    wait_req(a);
    cmp("wrap_first", a, 16'hFFFE);
    accept(0, 0, 0, 0, 0);
    wait_req(a);
    cmp("wrap_second", a, 16'h0000);

    // halt at accept
    accept(1, 16'h0020, 0, 0, 0);
    wait_valid();
    cmp("halt_pc_before", pc, 16'h0020);
    accept(0, 0, 0, 0, 1);
    cmp("halt_flag", halted, 1'b1);
    cmp("halt_pc", pc, 16'h0022);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) n++;
      cyc();
    end
    cmp("halt_no_req", 16'(n), 16'd0);

    // reset during WAIT with ack present
    ack_auto = 0; imem_ack = 0;
    Reset = 1; cyc(); Reset = 0;
    wait_req(a);
    cmp("rw_fetch", a, 16'h0000);
    cyc();
    imem_ack = 1; Reset = 1;
    cyc();
    cmp("rw_pc", pc, 16'h0000);
    cmp("rw_valid", instr_valid, 1'b0);
    cmp("rw_req", imem_req, 1'b0);
    Reset = 0;
    cyc();
    cmp("rw_refetch", imem_req, 1'b1);
    imem_ack = 0;

    // long missing ack
    for (int i = 0; i < 15; i++) cyc();
    cmp("tmo_still_wait", halted, 1'b0);
    cyc();
`ifdef PC_FETCH_TIMEOUT_EN
    cmp("tmo_err", fetch_error, 1'b1);
    cmp("tmo_halted", halted, 1'b1);
    cmp("tmo_pc", pc, 16'h0000);
`else
    cmp("tmo_err", fetch_error, 1'b0);
    cmp("tmo_halted", halted, 1'b0);
    cmp("tmo_req", imem_req, 1'b0);
`endif

    // randomized traffic
    Reset = 1; cyc(); Reset = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_ack      = ($urandom % 3) == 0;
      stall         = ($urandom % 3) == 0;
      jump_en       = ($urandom % 8) == 0;
      jump_target   = 16'($urandom);
      branch_taken  = ($urandom % 4) == 0;
      branch_offset = 16'($urandom);
      halt          = ($urandom % 30) == 0;
      Reset         = halted || (($urandom % 200) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
